dmem_hold_arbiter: RTL
======================

DMEM_HOLD_ARBITER -- requirements
Module: dmem_hold_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 16, giving the maximum consecutive granted cycles per DMA tenure (range 2..255).
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_we, cpu_addr, cpu_wd  in  1/32/32  CPU data-memory write enable, address, write data
- hold  in  2  bus request per DMA master (bit0 = master 0, bit1 = master 1)
- dma0_we, dma0_addr, dma0_wd  in  1/32/32  master 0 memory port
- dma1_we, dma1_addr, dma1_wd  in  1/32/32  master 1 memory port
- hold_ack  out  2  one-hot grant per master; 2'b11 never driven
- cpu_stall  out  1  CPU SHALL freeze its PC and register writes while high
- owner  out  2  00 = CPU, 01 = master 0, 10 = master 1
- dmem_we, dmem_addr, dmem_wd  out  1/32/32  muxed data-memory port

Function
REQ-003 The FSM SHALL have four states: IDLE, GRANT0, GRANT1 and RELEASE.
REQ-004 hold_ack, cpu_stall and owner SHALL be decoded from the registered state only, with no combinational path from hold.
REQ-005 IDLE and RELEASE SHALL drive owner = 00, hold_ack = 00, cpu_stall = 0, and route the cpu_* signals to dmem_*.
REQ-006 GRANTn SHALL drive hold_ack[n] = 1, owner = n+1 and cpu_stall = 1, and route the dman_* signals to dmem_*.
REQ-007 In GRANTn, dmem_we SHALL equal dman_we AND hold[n], so no write issues in the cycle a master drops hold.
REQ-008 IDLE SHALL go to GRANTn at the next edge if hold[n] is sampled high; the grant latency is therefore exactly 1 cycle from hold assertion.
REQ-009 If both hold bits are high in IDLE, the arbiter SHALL grant the master pointed to by a 1-bit round-robin pointer.
REQ-010 The round-robin pointer SHALL be set, on leaving GRANTn, to point at the other master.
REQ-011 GRANTn SHALL go to RELEASE when hold[n] is sampled low; hold_ack[n] falls 1 cycle after hold[n] falls.
REQ-012 RELEASE SHALL last exactly 1 cycle, then go to IDLE; this guarantees the CPU at least 2 bus cycles between consecutive DMA tenures.
REQ-013 A hold[n] pulse that is low at the IDLE sampling edge SHALL be ignored; requests are not latched.
REQ-014 The non-granted master's signals SHALL have no effect on dmem_* or on state while the other master is granted.
REQ-015 A CPU access presented in the same cycle as the IDLE-to-GRANT transition SHALL complete; the CPU owns that cycle.

Reset
REQ-016 Asserting rst low SHALL asynchronously force state = IDLE, pointer = master 0, burst counter = 0, hold_ack = 00, cpu_stall = 0 and owner = 00, including when reset occurs mid-grant.
REQ-017 After reset release, the first arbitration SHALL occur at the first rising edge with rst high.

Configuration
REQ-018 When macro DMEM_ARB_BURST_LIMIT_EN is defined:
- an 8-bit counter SHALL clear on entry to GRANTn and increment each GRANTn cycle;
- when the count reaches MAX_BURST, the FSM SHALL go to RELEASE even if hold[n] is still high;
- the pointer SHALL then favour the other master;
- a master still holding SHALL be re-arbitrated from IDLE.
REQ-019 When DMEM_ARB_BURST_LIMIT_EN is undefined, no counter SHALL exist and a grant SHALL persist until hold[n] drops.

Verification
REQ-020 Reset then hold = 01 at cycle 0 -> hold_ack = 01, cpu_stall = 1 and owner = 01 from cycle 1; dmem_addr = dma0_addr.
REQ-021 hold = 11 from reset -> master 0 granted first; drop hold[0] -> 1 cycle RELEASE, 1 cycle IDLE, then master 1 granted.
REQ-022 Master 0 granted with dma0_we = 1; deassert hold[0] -> dmem_we = 0 that same cycle; hold_ack = 00 the next cycle.
REQ-023 With DMEM_ARB_BURST_LIMIT_EN, MAX_BURST = 4, hold[0] held high -> 4 grant cycles, RELEASE, IDLE, re-grant; repeats periodically with cpu_stall low 2 of every 6 cycles.
REQ-024 Assert rst low in the middle of a GRANT1 cycle -> hold_ack = 00, cpu_stall = 0 and owner = 00 immediately, without waiting for a clock edge.
REQ-025 Without the macro, hold[1] held for 1000 cycles -> continuous grant with no RELEASE.

Source files
------------

// File: rtl/dmem_hold_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_hold_arbiter
// Shares the single data-memory port between the CPU and two DMA masters that
// request the bus with a HOLD/HOLD_ACK handshake. The CPU is the default owner;
// a granted master keeps the port until it drops its hold bit. A one-cycle
// RELEASE state after every tenure leaves the CPU at least two bus cycles
// (RELEASE + IDLE) between consecutive DMA tenures.
//
// Optional feature macro: DMEM_ARB_BURST_LIMIT_EN
//   When defined, an 8-bit burst counter caps each tenure at MAX_BURST granted
//   cycles, after which the master must re-arbitrate from IDLE. When undefined
//   there is no counter and a grant lasts until hold drops.
// -----------------------------------------------------------------------------
module dmem_hold_arbiter #(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  input  logic [1:0]  hold,
  input  logic        dma0_we,
  input  logic [31:0] dma0_addr,
  input  logic [31:0] dma0_wd,
  input  logic        dma1_we,
  input  logic [31:0] dma1_addr,
  input  logic [31:0] dma1_wd,
  output logic [1:0]  hold_ack,
  output logic        cpu_stall,
  output logic [1:0]  owner,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wd
);

  // Encoding is chosen so the grant states line up with owner/hold_ack.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT0  = 2'b01,
    GRANT1  = 2'b10,
    RELEASE = 2'b11
  } state_e;

  state_e state_q, state_d;

  // Round-robin pointer: 0 favours master 0, 1 favours master 1 on a tie.
  logic   rrPtr_q, rrPtr_d;

  // Asserted in the last permitted cycle of a tenure (never without the limit).
  logic   burstDone;

`ifdef DMEM_ARB_BURST_LIMIT_EN
  logic [7:0] burstCnt_q, burstCnt_d;

  // The counter reads 0 in the first granted cycle, so MAX_BURST-1 marks the
  // final one; the edge that leaves GRANT is the edge it would reach MAX_BURST.
  assign burstDone = (burstCnt_q == 8'(MAX_BURST - 1));

  // Burst counter next value: clear when a grant starts, count while granted.
  always_comb begin
    burstCnt_d = burstCnt_q;
    if ((state_q == IDLE) && ((state_d == GRANT0) || (state_d == GRANT1))) begin
      burstCnt_d = 8'd0;
    end else if ((state_q == GRANT0) || (state_q == GRANT1)) begin
      burstCnt_d = burstCnt_q + 8'd1;
    end
  end

  // Burst counter register, cleared by reset so a fresh tenure starts at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burstCnt_q <= 8'd0;
    end else begin
      burstCnt_q <= burstCnt_d;
    end
  end
`else
  assign burstDone = 1'b0;
`endif

  // State and pointer registers; reset returns the bus to the CPU at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rrPtr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rrPtr_q <= rrPtr_d;
    end
  end

  // Next-state logic: sample hold in IDLE, end a tenure when hold drops or the
  // burst limit is hit, and point the round-robin at the other master on exit.
  always_comb begin
    state_d = state_q;
    rrPtr_d = rrPtr_q;
    case (state_q)
      IDLE: begin
        if (hold[0] && hold[1]) begin
          state_d = rrPtr_q ? GRANT1 : GRANT0;
        end else if (hold[0]) begin
          state_d = GRANT0;
        end else if (hold[1]) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        if (!hold[0] || burstDone) begin
          state_d = RELEASE;
          rrPtr_d = 1'b1;
        end
      end
      GRANT1: begin
        if (!hold[1] || burstDone) begin
          state_d = RELEASE;
          rrPtr_d = 1'b0;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decoded purely from the registered state, so hold has no
  // combinational path to hold_ack, cpu_stall or owner.
  always_comb begin
    hold_ack  = 2'b00;
    cpu_stall = 1'b0;
    owner     = 2'b00;
    case (state_q)
      GRANT0: begin
        hold_ack  = 2'b01;
        cpu_stall = 1'b1;
        owner     = 2'b01;
      end
      GRANT1: begin
        hold_ack  = 2'b10;
        cpu_stall = 1'b1;
        owner     = 2'b10;
      end
      default: begin
        hold_ack  = 2'b00;
        cpu_stall = 1'b0;
        owner     = 2'b00;
      end
    endcase
  end

  // Memory port mux. A master's write is gated by its own hold bit so nothing
  // is written in the cycle it lets go of the bus; the idle master is ignored.
  always_comb begin
    dmem_we   = cpu_we;
    dmem_addr = cpu_addr;
    dmem_wd   = cpu_wd;
    case (state_q)
      GRANT0: begin
        dmem_we   = dma0_we & hold[0];
        dmem_addr = dma0_addr;
        dmem_wd   = dma0_wd;
      end
      GRANT1: begin
        dmem_we   = dma1_we & hold[1];
        dmem_addr = dma1_addr;
        dmem_wd   = dma1_wd;
      end
      default: begin
        dmem_we   = cpu_we;
        dmem_addr = cpu_addr;
        dmem_wd   = cpu_wd;
      end
    endcase
  end

endmodule
